// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell run LSB first, borrow held between cycles.
// Define SUB_ZERO_FLAG_EN to build the registered zero flag; otherwise zero is tied to 0.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             busy
);
    // state  | meaning
    // IDLE   | waiting for operands
    // RUN    | one bit per cycle through the cell
    // DONE   | result presented until consumed
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             bout_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             d_bit;
    logic             brw_d;
    logic [WIDTH-1:0] res_d;

    assign d_bit = sa_q[0] ^ sb_q[0] ^ brw_q;
    assign brw_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    assign res_d = {d_bit, res_q};

    // Gated by rst so the port reads 0 while reset is held yet is 1 in the first cycle after.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign busy      = busy_q;

`ifdef SUB_ZERO_FLAG_EN
    logic zero_q;
    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    brw_q <= brw_d;
                    res_q <= res_d[WIDTH-1:1];
                    cnt_q <= cnt_q + 1'b1;
                    // Result registers load only on the last bit, so no partial value is ever visible.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q      <= res_d;
                        bout_q      <= brw_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef SUB_ZERO_FLAG_EN
                        zero_q      <= ~|res_d;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor_ctrl;
`ifdef SUB_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic       in_valid8 = 1'b0, in_ready8, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       out_valid8, out_ready8 = 1'b0, bout8, zero8, busy8;

    logic       in_valid2 = 1'b0, in_ready2, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, diff2;
    logic       out_valid2, out_ready2 = 1'b0, bout2, zero2, busy2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .zero(zero8), .busy(busy8));

    serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .bout(bout2), .zero(zero2), .busy(busy2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({in_ready8, out_valid8, diff8, bout8, zero8, busy8} !== 13'd0) begin
            bad++;
            $display("FAIL reset_vals got rdy=%b ov=%b diff=%h bout=%b zero=%b busy=%b want all 0",
                     in_ready8, out_valid8, diff8, bout8, zero8, busy8);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b want 1", in_ready8);
        end
    endtask

    // One WIDTH=8 transaction; expected values come from plain integer subtraction.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, input int hold);
        logic [7:0] ed;
        logic       eb;
        logic       ez;
        int         n;
        int         tmp;
        tmp = int'(ta) - int'(tb_) - int'(tbin);
        ed  = tmp[7:0];
        eb  = (tmp < 0);
        ez  = ZEN && (ed == 8'd0);
        n = 0;
        while (in_ready8 !== 1'b1 && n < 50) begin tick(); n++; end
        a8 = ta; b8 = tb_; bin8 = tbin; in_valid8 = 1'b1;
        out_ready8 = (hold == 0);
        tick();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        total++;
        if (busy8 !== 1'b1 || in_ready8 !== 1'b0 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL accept busy=%b rdy=%b ov=%b want 1 0 0", busy8, in_ready8, out_valid8);
        end
        n = 0;
        while (out_valid8 !== 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL latency got %0d cycles want 8", n);
        end
        total++;
        if (diff8 !== ed || bout8 !== eb || zero8 !== ez) begin
            bad++;
            $display("FAIL result a=%h b=%h bin=%b got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
                     ta, tb_, tbin, diff8, bout8, zero8, ed, eb, ez);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1;
            tick();
            total++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || diff8 !== ed || bout8 !== eb || busy8 !== 1'b1) begin
                bad++;
                $display("FAIL hold cyc%0d got ov=%b rdy=%b diff=%h bout=%b busy=%b want 1 0 %h %b 1",
                         i, out_valid8, in_ready8, diff8, bout8, busy8, ed, eb);
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0 || diff8 !== ed) begin
            bad++;
            $display("FAIL release got ov=%b rdy=%b busy=%b diff=%h want 0 1 0 %h",
                     out_valid8, in_ready8, busy8, diff8, ed);
        end
    endtask

    task automatic test_directed();
        op8(8'h5A, 8'h3C, 1'b0, 0);
        op8(8'h00, 8'h01, 1'b0, 0);
        op8(8'h10, 8'h10, 1'b1, 1);
        op8(8'h33, 8'h33, 1'b0, 0);
        op8(8'h00, 8'hFF, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_backpressure();
        op8(8'hC7, 8'h21, 1'b1, 5);
        total++;
        if (diff8 !== 8'hA5) begin
            bad++;
            $display("FAIL bp_retain got diff=%h want a5", diff8);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({in_ready8, out_valid8, diff8, bout8, zero8, busy8} !== 13'd0) begin
            bad++;
            $display("FAIL midop_reset got rdy=%b ov=%b diff=%h bout=%b zero=%b busy=%b want all 0",
                     in_ready8, out_valid8, diff8, bout8, zero8, busy8);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midop_no_result got %0d active cycles want 0", seen);
        end
        out_ready8 = 1'b0;
        op8(8'hFF, 8'h01, 1'b0, 0);
    endtask

    task automatic test_exhaustive_w2();
        int last_acc;
        int n;
        int tmp;
        logic [1:0] ed;
        logic eb, ez;
        last_acc = -1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a2 = i[4:3]; b2 = i[2:1]; bin2 = i[0];
            tmp = int'(i[4:3]) - int'(i[2:1]) - int'(i[0]);
            ed = tmp[1:0];
            eb = (tmp < 0);
            ez = ZEN && (ed == 2'd0);
            in_valid2 = 1'b1;
            n = 0;
            while (in_ready2 !== 1'b1 && n < 20) begin tick(); n++; end
            tick();
            if (last_acc >= 0) begin
                total++;
                if (cyc - last_acc != 4) begin
                    bad++;
                    $display("FAIL w2_spacing idx=%0d got %0d want 4", i, cyc - last_acc);
                end
            end
            last_acc = cyc;
            n = 0;
            while (out_valid2 !== 1'b1 && n < 20) begin tick(); n++; end
            total++;
            if (diff2 !== ed || bout2 !== eb || zero2 !== ez) begin
                bad++;
                $display("FAIL w2_result idx=%0d got diff=%0d bout=%b zero=%b want diff=%0d bout=%b zero=%b",
                         i, diff2, bout2, zero2, ed, eb, ez);
            end
        end
        in_valid2 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midop();
        test_exhaustive_w2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller built around a single one-bit full-subtractor cell, with a borrow register between cycles. It accepts two WIDTH-bit operands plus a borrow-in over a valid/ready handshake and runs the cell once per clock, LSB first. It returns the WIDTH-bit difference and the final borrow over a second valid/ready handshake. It is the sequencing layer that turns the one-bit subtractor into a word-level arithmetic resource for a slow-path datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on a/b/bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in to bit 0
- out_valid  output  1  diff/bout/zero are valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out of bit WIDTH-1; 1 means a < b + bin as unsigned values
- zero  output  1  diff == 0; feature-gated, see Configuration
- busy  output  1  high in RUN and DONE

Decided: one clock, clk; reset rst is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a and b into shift registers sa and sb, set borrow register brw=bin, set bit counter cnt=0, and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle:
    - d = sa[0]^sb[0]^brw
    - brw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)
    - sa and sb shift right by 1
    - result register shifts right with d entering at the MSB
    - cnt increments
  - When cnt==WIDTH-1 is processed, go to DONE.
- DONE:
  - out_valid=1.
  - diff, bout and zero are held stable until out_valid&&out_ready; then go to IDLE.
  - in_ready=0 throughout DONE, so no overlap of a new operation with an unconsumed result.
- diff is a registered output. It does not change in IDLE after a transaction; the last result is retained.
- Inputs a, b and bin are sampled only on the accept edge. Later changes have no effect.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no signed overflow detection.

## Timing
- Reset values, forced while rst=1 on every clock edge:
  - state=IDLE, in_ready=0, out_valid=0, diff=0, bout=0, zero=0, busy=0.
- in_ready is 1 in the first IDLE cycle after rst deasserts.
- Latency: accept at edge E → out_valid=1 in the cycle following edge E+WIDTH.
- Minimum spacing between accepts is WIDTH+2 cycles: 1 IDLE, WIDTH RUN, 1 DONE, with out_ready held high.
- out_ready stuck low: remain in DONE indefinitely with outputs stable.
- out_ready high before out_valid has no effect.
- in_valid in RUN or DONE is ignored and not queued.
- rst asserted in any state, including mid-RUN, aborts the operation at that edge. No partial result is ever presented.
- Simultaneous rst and handshake: rst wins.

## Configuration
- SUB_ZERO_FLAG_EN defined:
  - zero is registered at the RUN→DONE transition as the NOR of the final result.
  - zero is valid with out_valid and held with diff.
- SUB_ZERO_FLAG_EN undefined:
  - zero logic is not built and the port is tied to 0.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Basic: a=0x5A, b=0x3C, bin=0 → diff=0x1E, bout=0, zero=0; out_valid exactly 8 cycles after the accept edge.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Also a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1.
- Zero flag: a=0x33, b=0x33, bin=0 → diff=0x00, bout=0. zero=1 with SUB_ZERO_FLAG_EN, zero=0 without it.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: diff, bout and out_valid stable and in_ready=0; a new in_valid pulse during this time is ignored. Release out_ready → in_ready=1 the next cycle.
- Reset mid-op: assert rst for 1 cycle at the 3rd RUN cycle. Required: all outputs at reset values, no out_valid. A following op a=0xFF, b=0x01, bin=0 → diff=0xFE, bout=0.
- Exhaustive: WIDTH=2, all 32 combinations of a, b and bin, back-to-back with out_ready=1. Each result must match (a-b-bin) mod 4 and the borrow, and accepts must be spaced exactly 4 cycles apart.
